temporizador_param: RTL and testbench
=====================================

# temporizador_param

Parametrised countdown timer: the next generation of the team's counter-plus-FSM timer. It loads a start value, decrements once per prescaler period and pulses `fin` when it reaches zero. New in this generation: configurable counter width and prescaler divisor, pause, abort, a busy flag, an exported tick strobe, and a compile-time auto-reload mode. It sits between a control FSM (which drives `inicio`/`datos`) and display or sequencing logic (which consumes `cuenta`/`fin`).

## Interface
- `ANCHO`, 8, width of `datos`/`cuenta`; ≥1.
- `DIV`, 100000000, clk cycles per count step (1 s at 100 MHz); ≥1; prescaler width clog2(DIV), min 1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `inicio` in 1: start request, sampled only in IDLE.
- `pausa` in 1: level; freezes prescaler and `cuenta` while high in RUN.
- `abortar` in 1: level; returns to IDLE, clears count, no `fin`.
- `recarga` in 1: auto-reload request, sampled with `inicio` (only with macro).
- `datos` in ANCHO: start value, sampled with `inicio`.
- `cuenta` out ANCHO: current count (registered).
- `fin` out 1: one-cycle pulse on reaching zero (registered).
- `ocupado` out 1: high in RUN.
- `tick` out 1: one-cycle pulse at each decrement.

## Operation
- States: IDLE, RUN. Reset → IDLE, `cuenta`=0, `fin`=0, `ocupado`=0, `tick`=0, prescaler=0, reload flag=0.
- Priority each cycle: `rst` > `abortar` > `pausa` > prescaler/count update.
- IDLE, `inicio`=1, `datos`≠0: next edge `cuenta`←`datos`, reload value←`datos`, reload flag←`recarga` (macro only), prescaler←0, state RUN.
- IDLE, `inicio`=1, `datos`=0: `cuenta`←0, `fin`=1 for one cycle, stay IDLE; reload ignored.
- RUN, `pausa`=0: prescaler increments; when prescaler = DIV−1, prescaler←0, `tick`=1 for one cycle, `cuenta`←`cuenta`−1.
- Decrement from 1 to 0: `fin`=1 in the same cycle `cuenta` shows 0. One-shot: state←IDLE. Reload flag set: `cuenta`←reload value in the following tick period (see Timing), state stays RUN.
- RUN, `pausa`=1: prescaler, `cuenta` hold; `tick`=0; `ocupado` stays 1. Release resumes from held prescaler value.
- `abortar`=1 in any state: next edge state IDLE, `cuenta`←0, prescaler←0, reload flag←0, `fin`=0, `tick`=0.
- `inicio` in RUN ignored (no restart). `datos` changes after load ignored.
- `cuenta` never wraps; no decrement below 0.

## Timing
- Load edge = edge where IDLE samples `inicio`=1. `cuenta`=`datos` visible after it; `ocupado`=1 same cycle.
- k-th `tick` and decrement occur k·DIV cycles after load edge (no pause). `fin` at N·DIV cycles for `datos`=N; `ocupado` drops the cycle after `fin` (one-shot).
- Reload mode: on the edge where `cuenta` reaches 0 with `fin`=1, prescaler restarts at 0; on the next edge `cuenta`←reload value. Subsequent `fin` every N·DIV cycles; `cuenta` shows 0 for exactly one cycle per period.
- DIV=1: `tick` every RUN cycle.
- `pausa` asserted same cycle as terminal prescaler value: pause wins, no tick.
- `abortar` same cycle as final decrement: abort wins, no `fin`.
- `inicio` the cycle after one-shot `fin`: accepted (IDLE reached).

## Configuration
- `TEMPORIZADOR_RECARGA_EN` defined: `recarga` sampled at load; auto-reload behaviour as above.
- Undefined: `recarga` port present but ignored; reload flag and reload register removed; every run is one-shot.

## Test plan
- DIV=4, ANCHO=4, `datos`=3, `inicio` pulse → `cuenta` 3,2,1,0 at +0,+4,+8,+12; `fin` one cycle at +12; `ocupado` 0 at +13.
- `datos`=0, `inicio` → `fin`=1 next cycle, `ocupado` never 1, `cuenta`=0.
- `datos`=5, `pausa` high 10 cycles at +6 → `fin` at +30 instead of +20; no `tick` during pause.
- `datos`=5, `abortar` at +9 → IDLE next edge, `cuenta`=0, no `fin`; `inicio` at +10 with `datos`=2 → `fin` at +18 after that load.
- Macro on, `recarga`=1, `datos`=2 → `fin` at +8, +16, +24; `cuenta` 2,1,0,2,…; `abortar` stops it. Macro off, same stimulus → single `fin` at +8.
- `rst` mid-RUN (`cuenta`=3) → next edge all outputs 0, IDLE; `inicio` during RUN → no effect.

Source files
------------

// File: rtl/temporizador_param.sv
// temporizador_param: parametrised countdown timer with prescaler, pause,
// abort, busy flag and exported tick strobe.
// Optional feature: define TEMPORIZADOR_RECARGA_EN to enable auto-reload
// (recarga sampled at load, count restarts from the loaded value after
// each fin). Without it every run is one-shot and recarga is ignored.
module temporizador_param #(
    parameter int ANCHO = 8,
    parameter int DIV   = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic             pausa,
    input  logic             abortar,
    input  logic             recarga,
    input  logic [ANCHO-1:0] datos,
    output logic [ANCHO-1:0] cuenta,
    output logic             fin,
    output logic             ocupado,
    output logic             tick
);

    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    estado_t          estado, estado_sig;
    logic [PW-1:0]    pre, pre_sig;
    logic [ANCHO-1:0] cuenta_sig;
    logic [ANCHO-1:0] base;
    logic             fin_sig, tick_sig, ocupado_sig;

`ifdef TEMPORIZADOR_RECARGA_EN
    logic [ANCHO-1:0] valor_rec, valor_rec_sig;
    logic             rec_flag, rec_flag_sig;
`else
    // recarga has no function in the one-shot build
    logic unused_recarga;
    assign unused_recarga = recarga;
`endif

    // Next-state, next-count, prescaler and strobe computation
    always_comb begin
        estado_sig  = estado;
        pre_sig     = pre;
        cuenta_sig  = cuenta;
        base        = cuenta;
        fin_sig     = 1'b0;
        tick_sig    = 1'b0;
        ocupado_sig = 1'b0;
`ifdef TEMPORIZADOR_RECARGA_EN
        valor_rec_sig = valor_rec;
        rec_flag_sig  = rec_flag;
`endif
        if (abortar) begin
            // abort beats everything except reset: silent return to IDLE
            estado_sig = IDLE;
            cuenta_sig = '0;
            pre_sig    = '0;
`ifdef TEMPORIZADOR_RECARGA_EN
            rec_flag_sig = 1'b0;
`endif
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        if (datos != '0) begin
                            estado_sig  = RUN;
                            cuenta_sig  = datos;
                            pre_sig     = '0;
                            ocupado_sig = 1'b1;
`ifdef TEMPORIZADOR_RECARGA_EN
                            valor_rec_sig = datos;
                            rec_flag_sig  = recarga;
`endif
                        end else begin
                            // zero start value finishes immediately
                            cuenta_sig = '0;
                            fin_sig    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // busy holds through pause and through the fin cycle
                    ocupado_sig = 1'b1;
                    if (!pausa) begin
`ifdef TEMPORIZADOR_RECARGA_EN
                        // the cycle after a reload-mode fin restores the start value
                        if (rec_flag && (cuenta == '0)) begin
                            base = valor_rec;
                        end
`endif
                        cuenta_sig = base;
                        if (pre == PRE_MAX) begin
                            pre_sig = '0;
                            if (base != '0) begin
                                tick_sig   = 1'b1;
                                cuenta_sig = base - 1'b1;
                                if (base == ANCHO'(1)) begin
                                    fin_sig = 1'b1;
`ifdef TEMPORIZADOR_RECARGA_EN
                                    if (!rec_flag) begin
                                        estado_sig = IDLE;
                                    end
`else
                                    estado_sig = IDLE;
`endif
                                end
                            end
                        end else begin
                            pre_sig = pre + 1'b1;
                        end
                    end
                end
                default: estado_sig = IDLE;
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            pre     <= '0;
            cuenta  <= '0;
            fin     <= 1'b0;
            tick    <= 1'b0;
            ocupado <= 1'b0;
`ifdef TEMPORIZADOR_RECARGA_EN
            rec_flag <= 1'b0;
`endif
        end else begin
            estado  <= estado_sig;
            pre     <= pre_sig;
            cuenta  <= cuenta_sig;
            fin     <= fin_sig;
            tick    <= tick_sig;
            ocupado <= ocupado_sig;
`ifdef TEMPORIZADOR_RECARGA_EN
            rec_flag <= rec_flag_sig;
`endif
        end
    end

`ifdef TEMPORIZADOR_RECARGA_EN
    // Reload value is pure data and needs no reset
    always_ff @(posedge clk) begin
        valor_rec <= valor_rec_sig;
    end
`endif

endmodule

// File: tb/tb_temporizador_param.sv
// Testbench for temporizador_param (ANCHO=4, DIV=4): directed scenarios plus
// randomized traffic, each checked against an elapsed-time reference model.
module tb_temporizador_param;

    localparam int ANCHO = 4;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inicio = 1'b0, pausa = 1'b0, abortar = 1'b0, recarga = 1'b0;
    logic [ANCHO-1:0] datos = '0;
    logic [ANCHO-1:0] cuenta;
    logic             fin, ocupado, tick;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: elapsed un-paused RUN cycles since load / last fin
    bit               m_run, m_rel;
    int               m_n, m_e;
    logic [ANCHO-1:0] m_cuenta;
    logic             m_fin, m_tick, m_ocup;

    temporizador_param #(.ANCHO(ANCHO), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .pausa(pausa),
        .abortar(abortar), .recarga(recarga), .datos(datos),
        .cuenta(cuenta), .fin(fin), .ocupado(ocupado), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {cuenta, fin, ocupado, tick};
    endfunction

    function automatic logic [6:0] expv();
        return {m_cuenta, m_fin, m_ocup, m_tick};
    endfunction

    task automatic model_edge();
        m_fin  = 1'b0;
        m_tick = 1'b0;
        if (rst || abortar) begin
            m_run = 0; m_rel = 0; m_e = 0; m_cuenta = '0; m_ocup = 1'b0;
        end else if (!m_run) begin
            m_ocup = 1'b0;
            if (inicio) begin
                if (datos != '0) begin
                    m_run = 1; m_n = int'(datos); m_e = 0;
                    m_cuenta = datos; m_ocup = 1'b1;
`ifdef TEMPORIZADOR_RECARGA_EN
                    m_rel = recarga;
`else
                    m_rel = 0;
`endif
                end else begin
                    m_cuenta = '0; m_fin = 1'b1;
                end
            end
        end else if (!pausa) begin
            m_ocup = 1'b1;
            m_e++;
            if (m_e % DIV == 0) m_tick = 1'b1;
            m_cuenta = ANCHO'(m_n - m_e / DIV);
            if (m_e == m_n * DIV) begin
                m_fin = 1'b1;
                m_e   = 0;
                if (!m_rel) m_run = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        {inicio, pausa, abortar, recarga} = '0;
        datos = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        {inicio, pausa, abortar, recarga} = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs() !== 7'd0) begin
                n_fail++;
                $display("FAIL reset c%0d got %h want 00", i, obs());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        int fin_at = -1;
        go_idle();
        datos = 4'd3; inicio = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL oneshot c%0d got %h want %h", i, obs(), expv());
            end
            if (fin === 1'b1) fin_at = i;
            if (i == 13) begin
                n_cmp++;
                if (ocupado !== 1'b0) begin
                    n_fail++;
                    $display("FAIL oneshot_ocupado got %b want 0", ocupado);
                end
            end
        end
        n_cmp++;
        if (fin_at != 12) begin
            n_fail++;
            $display("FAIL oneshot_fin_cycle got %0d want 12", fin_at);
        end
    endtask

    task automatic test_zero();
        go_idle();
        datos = 4'd0; inicio = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== {4'd0, (i == 0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL zero c%0d got %h want %h", i, obs(), {4'd0, (i == 0), 2'b00});
            end
        end
    endtask

    task automatic test_pause();
        int fin_at = -1;
        go_idle();
        datos = 4'd5; inicio = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            pausa = (i >= 6 && i <= 15);
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL pause c%0d got %h want %h", i, obs(), expv());
            end
            if (pausa && tick !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_tick c%0d got %b want 0", i, tick);
            end
            if (fin === 1'b1) fin_at = i;
        end
        pausa = 1'b0;
        n_cmp++;
        if (fin_at != 30) begin
            n_fail++;
            $display("FAIL pause_fin_cycle got %0d want 30", fin_at);
        end
    endtask

    task automatic test_abort();
        int fin_at = -1;
        go_idle();
        datos = 4'd5; inicio = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            abortar = (i == 9);
            if (i == 10) begin inicio = 1'b1; datos = 4'd2; end
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL abort c%0d got %h want %h", i, obs(), expv());
            end
            if (i == 9) begin
                n_cmp++;
                if ({cuenta, fin, ocupado} !== 6'd0) begin
                    n_fail++;
                    $display("FAIL abort_clear got %h want 00", {cuenta, fin, ocupado});
                end
            end
            if (fin === 1'b1) fin_at = i;
        end
        abortar = 1'b0;
        n_cmp++;
        if (fin_at != 18) begin
            n_fail++;
            $display("FAIL abort_fin_cycle got %0d want 18", fin_at);
        end
    endtask

    task automatic test_reload();
        int nfin = 0;
        int want;
`ifdef TEMPORIZADOR_RECARGA_EN
        want = 3;
`else
        want = 1;
`endif
        go_idle();
        datos = 4'd2; recarga = 1'b1; inicio = 1'b1;
        for (int i = 0; i <= 34; i++) begin
            abortar = (i == 27);
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL reload c%0d got %h want %h", i, obs(), expv());
            end
            if (fin === 1'b1) nfin++;
        end
        abortar = 1'b0; recarga = 1'b0;
        n_cmp++;
        if (nfin != want) begin
            n_fail++;
            $display("FAIL reload_fin_count got %0d want %0d", nfin, want);
        end
    endtask

    task automatic test_rst_midrun();
        go_idle();
        datos = 4'd5; inicio = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            rst = (i == 9);
            if (i >= 1 && i <= 8) begin inicio = 1'b1; datos = 4'd9; end
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL rst_midrun c%0d got %h want %h", i, obs(), expv());
            end
            if (i == 8) begin
                n_cmp++;
                if (cuenta !== 4'd3) begin
                    n_fail++;
                    $display("FAIL rst_midrun_cuenta got %0d want 3", cuenta);
                end
            end
            if (i == 9) begin
                n_cmp++;
                if (obs() !== 7'd0) begin
                    n_fail++;
                    $display("FAIL rst_midrun_clear got %h want 00", obs());
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int fin_at = -1;
        go_idle();
        datos = 4'd1; inicio = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            if (i == 5) begin inicio = 1'b1; datos = 4'd2; end
            step();
            inicio = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL back_to_back c%0d got %h want %h", i, obs(), expv());
            end
            if (i <= 13 && ocupado !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back_ocupado c%0d got %b want 1", i, ocupado);
            end
            if (fin === 1'b1) fin_at = i;
        end
        n_cmp++;
        if (fin_at != 13) begin
            n_fail++;
            $display("FAIL back_to_back_fin_cycle got %0d want 13", fin_at);
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) < 1);
            abortar = ($urandom_range(0, 99) < 3);
            pausa   = ($urandom_range(0, 99) < 20);
            inicio  = ($urandom_range(0, 99) < 30);
            recarga = $urandom_range(0, 1);
            datos   = ANCHO'($urandom_range(0, 4));
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random c%0d got %h want %h", i, obs(), expv());
            end
        end
        {rst, abortar, pausa, inicio, recarga} = '0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_zero();
        test_pause();
        test_abort();
        test_reload();
        test_rst_midrun();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
